// File: rtl/mac_result_drain.sv
// Consumer side of the 4-lane MAC: aligns beats with the MAC pipeline, accumulates each
// group into a saturating signed sum and drains completed sums through a small FWFT FIFO.
module mac_result_drain #(
    parameter int MAC_LATENCY = 2,
    parameter int ACC_W       = 32,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    input  logic [17:0]      mac_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             out_ovf,
    output logic [15:0]      out_beats
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int EW = ACC_W + 1 + 16;

    // Signed saturating add; returns {overflow, saturated sum}.
    function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [ACC_W-1:0] b);
        logic [ACC_W:0] wide;
        logic [ACC_W:0] res;
        wide = {a[ACC_W-1], a} + {b[ACC_W-1], b};
        if (wide[ACC_W] != wide[ACC_W-1]) begin
            res = {1'b1, (wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                      : {1'b0, {(ACC_W-1){1'b1}}})};
        end else begin
            res = {1'b0, wide[ACC_W-1:0]};
        end
        return res;
    endfunction

    logic                   in_ready_r;
    logic [MAC_LATENCY-1:0] pv_r;
    logic [MAC_LATENCY-1:0] pl_r;
    logic [ACC_W-1:0]       acc_r;
    logic                   ovf_r;
    logic [15:0]            beats_r;
    logic [CW-1:0]          credits_r;
    logic [EW-1:0]          mem_r [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_r;
    logic [AW-1:0]          rd_ptr_r;
    logic [CW-1:0]          count_r;
    logic                   out_valid_r;
    logic [ACC_W-1:0]       out_data_r;
    logic                   out_ovf_r;
    logic [15:0]            out_beats_r;

    logic                   accept_s;
    logic                   d_valid_s;
    logic                   d_last_s;
    logic [ACC_W-1:0]       res_ext_s;
    logic [ACC_W-1:0]       sum_next_s;
    logic                   add_ovf_s;
    logic                   ovf_next_s;
    logic [15:0]            beats_next_s;
    logic                   push_s;
    logic                   pop_s;
    logic [EW-1:0]          push_data_s;
    logic [CW-1:0]          credits_next_s;
    logic [CW-1:0]          count_next_s;
    logic [CW-1:0]          remain_s;
    logic [AW-1:0]          rd_ptr_next_s;
    logic [EW-1:0]          head_next_s;

    assign accept_s  = in_valid & in_ready_r;
    assign d_valid_s = pv_r[MAC_LATENCY-1];
    assign d_last_s  = pl_r[MAC_LATENCY-1];
    assign res_ext_s = {{(ACC_W-17){mac_result[17]}}, mac_result[16:0]};
    assign pop_s     = out_valid_r & out_ready;

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_ovf   = out_ovf_r;
    assign out_beats = out_beats_r;

    // Accumulate datapath and the FIFO entry a closing beat would push.
    always_comb begin
        {add_ovf_s, sum_next_s} = sat_add(acc_r, res_ext_s);
        ovf_next_s   = ovf_r | add_ovf_s;
        beats_next_s = (beats_r == 16'hFFFF) ? 16'hFFFF : (beats_r + 16'd1);
        push_s       = d_valid_s & d_last_s;
        push_data_s  = {sum_next_s, ovf_next_s, beats_next_s};
    end

    // Credit and FIFO bookkeeping; the next head is computed so outputs can be registered.
    always_comb begin
        credits_next_s = credits_r;
        if ((accept_s & in_last) && !pop_s) begin
            credits_next_s = credits_r + CW'(1);
        end else if (!(accept_s & in_last) && pop_s) begin
            credits_next_s = credits_r - CW'(1);
        end else begin
            credits_next_s = credits_r;
        end
        remain_s      = pop_s ? (count_r - CW'(1)) : count_r;
        count_next_s  = push_s ? (remain_s + CW'(1)) : remain_s;
        rd_ptr_next_s = pop_s ? (rd_ptr_r + AW'(1)) : rd_ptr_r;
        // An entry pushed into an otherwise empty FIFO falls straight through to the head.
        if (remain_s == CW'(0)) begin
            head_next_s = push_data_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // Beat-alignment shift register tracking the MAC pipeline.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pv_r <= '0;
            pl_r <= '0;
        end else begin
            pv_r[0] <= accept_s;
            pl_r[0] <= accept_s & in_last;
            for (int i = 1; i < MAC_LATENCY; i++) begin
                pv_r[i] <= pv_r[i-1];
                pl_r[i] <= pl_r[i-1];
            end
        end
    end

    // Group accumulator; clears on the closing beat so the next beat starts a fresh group.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            beats_r <= 16'd0;
        end else if (push_s) begin
            acc_r   <= '0;
            ovf_r   <= 1'b0;
            beats_r <= 16'd0;
        end else if (d_valid_s) begin
            acc_r   <= sum_next_s;
            ovf_r   <= ovf_next_s;
            beats_r <= beats_next_s;
        end else begin
            acc_r   <= acc_r;
            ovf_r   <= ovf_r;
            beats_r <= beats_r;
        end
    end

    // Credits bound in-flight plus queued groups so a push never meets a full FIFO.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            credits_r  <= '0;
            in_ready_r <= 1'b1;
        end else begin
            credits_r  <= credits_next_s;
            in_ready_r <= (credits_next_s < CW'(FIFO_DEPTH));
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= push_data_s;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Registered head; data fields hold their last value while the FIFO is empty.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_ovf_r   <= 1'b0;
            out_beats_r <= 16'd0;
        end else if (count_next_s != CW'(0)) begin
            out_valid_r <= 1'b1;
            {out_data_r, out_ovf_r, out_beats_r} <= head_next_s;
        end else begin
            out_valid_r <= 1'b0;
            out_data_r  <= out_data_r;
            out_ovf_r   <= out_ovf_r;
            out_beats_r <= out_beats_r;
        end
    end

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: directed scenarios plus random traffic against a group-level
// reference model; a second instance with an 18-bit accumulator exercises saturation.
module tb_mac_result_drain;

    localparam int L     = 2;
    localparam int DEPTH = 4;

    typedef struct {
        longint sum32;
        bit     ovf32;
        longint sum18;
        bit     ovf18;
        int     beats;
        int     due;
    } grp_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;
    logic [17:0] mac_result = 18'd0;
    logic        in_ready, out_valid, out_ovf;
    logic [31:0] out_data;
    logic [15:0] out_beats;
    logic        in_ready18, out_valid18, out_ovf18;
    logic [17:0] out_data18;
    logic [15:0] out_beats18;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int outstanding = 0;
    int max_out = 0;
    int n_acc = 0;
    int n_pop = 0;
    grp_t exp_q[$];
    int cur_vals[$];
    logic [17:0] dq[$];
    longint last32 = 0;
    longint last18 = 0;
    longint obs32 = 0;
    longint obs18 = 0;
    int obs_beats = 0;
    int obs_ovf18 = 0;

    mac_result_drain #(.MAC_LATENCY(L), .ACC_W(32), .FIFO_DEPTH(DEPTH)) u_dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready), .mac_result(mac_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_ovf(out_ovf), .out_beats(out_beats));

    mac_result_drain #(.MAC_LATENCY(L), .ACC_W(18), .FIFO_DEPTH(DEPTH)) u_dut18 (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready18), .mac_result(mac_result), .out_valid(out_valid18),
        .out_ready(out_ready), .out_data(out_data18), .out_ovf(out_ovf18), .out_beats(out_beats18));

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: saturating sum of a whole group computed with plain integer arithmetic.
    function automatic void group_sum(input int w, output longint s, output bit o);
        longint mx, mn;
        mx = (longint'(1) <<< (w - 1)) - 1;
        mn = -(longint'(1) <<< (w - 1));
        s = 0;
        o = 1'b0;
        foreach (cur_vals[i]) begin
            s += cur_vals[i];
            if (s > mx) begin s = mx; o = 1'b1; end
            else if (s < mn) begin s = mn; o = 1'b1; end
        end
    endfunction

    task automatic refill_dq();
        dq.delete();
        for (int i = 0; i < L; i++) dq.push_back(18'($urandom));
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_valid18", out_valid18, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_out_beats", out_beats, 0);
        check("rst_out_ovf", out_ovf, 0);
        exp_q.delete();
        cur_vals.delete();
        outstanding = 0;
        last32 = 0;
        last18 = 0;
        refill_dq();
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    // One clock cycle: drive at posedge+1, check and update the model at negedge.
    task automatic step(input bit v, input bit l, input int val, input bit ordy);
        bit acc;
        bit head_rdy;
        grp_t g;
        mac_result = dq.pop_front();
        in_valid = v;
        in_last = l;
        out_ready = ordy;
        @(negedge clk);
        check("in_ready", in_ready, outstanding < DEPTH);
        check("in_ready18", in_ready18, outstanding < DEPTH);
        head_rdy = (exp_q.size() > 0) && (exp_q[0].due <= cyc);
        check("out_valid", out_valid, head_rdy);
        check("out_valid18", out_valid18, head_rdy);
        if (out_valid && exp_q.size() > 0) begin
            check("data32", $signed(out_data), exp_q[0].sum32);
            check("ovf32", out_ovf, exp_q[0].ovf32);
            check("beats", out_beats, exp_q[0].beats);
            check("data18", $signed(out_data18), exp_q[0].sum18);
            check("ovf18", out_ovf18, exp_q[0].ovf18);
            if (ordy) begin
                last32 = exp_q[0].sum32;
                last18 = exp_q[0].sum18;
                obs32 = $signed(out_data);
                obs18 = $signed(out_data18);
                obs_beats = out_beats;
                obs_ovf18 = out_ovf18;
                void'(exp_q.pop_front());
                outstanding--;
                n_pop++;
            end
        end else if (!out_valid) begin
            check("hold32", $signed(out_data), last32);
            check("hold18", $signed(out_data18), last18);
        end
        acc = v && in_ready;
        if (acc) begin
            n_acc++;
            cur_vals.push_back(val);
            if (l) begin
                group_sum(32, g.sum32, g.ovf32);
                group_sum(18, g.sum18, g.ovf18);
                g.beats = (cur_vals.size() > 65535) ? 65535 : cur_vals.size();
                g.due = cyc + L + 1;
                exp_q.push_back(g);
                cur_vals.delete();
                outstanding++;
                if (outstanding > max_out) max_out = outstanding;
            end
        end
        dq.push_back(acc ? 18'(val) : 18'($urandom));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((exp_q.size() > 0 || k < L + 2) && k < 80) begin
            step(1'b0, 1'b0, 0, 1'b1);
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        int k;
        int start_acc;
        @(posedge clk);
        #1;
        do_reset();

        // 8 beats of result 4
        for (int i = 0; i < 8; i++) step(1'b1, i == 7, 4, 1'b1);
        drain();
        check("t1_data", obs32, 32);
        check("t1_beats", obs_beats, 8);

        // 3 beats of -16256
        for (int i = 0; i < 3; i++) step(1'b1, i == 2, -16256, 1'b1);
        drain();
        check("t2_data", obs32, -48768);
        check("t2_beats", obs_beats, 3);

        // credit stall with downstream blocked
        start_acc = n_acc;
        for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 100 + i, 1'b0);
        check("t3_accepted", n_acc - start_acc, 4);
        check("t3_in_ready_low", in_ready, 0);
        k = 0;
        while (n_acc - start_acc < 6 && k < 40) begin
            step(1'b1, 1'b1, 100 + n_acc - start_acc, 1'b1);
            k++;
        end
        check("t3_all_issued", n_acc - start_acc, 6);
        drain();
        check("t3_last_data", obs32, 105);

        // saturation on the 18-bit instance, then a clean group
        for (int i = 0; i < 3; i++) step(1'b1, i == 2, 65535, 1'b1);
        drain();
        check("t4_data18", obs18, 131071);
        check("t4_ovf18", obs_ovf18, 1);
        check("t4_data32", obs32, 196605);
        step(1'b1, 1'b1, 1, 1'b1);
        drain();
        check("t4_next_ovf18", obs_ovf18, 0);
        check("t4_next_data18", obs18, 1);

        // reset mid-group: 3 beats delivered, 1 in flight
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 7, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);
        do_reset();
        for (int i = 0; i < 2; i++) step(1'b1, i == 1, 4, 1'b1);
        drain();
        check("t5_data", obs32, 8);
        check("t5_beats", obs_beats, 2);

        // random traffic
        start_acc = n_acc;
        k = 0;
        while (n_acc - start_acc < 10000 && k < 40000) begin
            int val;
            logic [17:0] r;
            case ($urandom_range(0, 7))
                0: val = 131071;
                1: val = -131072;
                default: begin
                    r = 18'($urandom);
                    val = $signed(r);
                end
            endcase
            step($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, val,
                 $urandom_range(0, 9) < 6);
            k++;
        end
        check("t6_beats_issued", n_acc - start_acc >= 10000, 1);
        step(1'b1, 1'b1, 3, 1'b1);
        drain();
        check("max_outstanding_ok", max_out <= DEPTH, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
